// File: rtl/zap_shift_stage.sv
// Shift stage ahead of the ALU: resolves operands by forwarding from the ALU and memory stages,
// shifts the source, and registers the result and carry-out. Raises a load-use bubble when needed.
module zap_shift_stage #(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned SHIFT_OPS = 7
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear_from_alu,
  input  logic                         i_stall_from_alu,
  input  logic                         i_dav,
  input  logic [IDX_W-1:0]             i_src_index,
  input  logic                         i_src_imm,
  input  logic [31:0]                  i_imm_value,
  input  logic [31:0]                  i_src_rf_value,
  input  logic [IDX_W-1:0]             i_amt_index,
  input  logic                         i_amt_is_reg,
  input  logic [7:0]                   i_amt_imm,
  input  logic [31:0]                  i_amt_rf_value,
  input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
  input  logic                         i_cpsr_c,
  input  logic [IDX_W-1:0]             i_rd_index,
  input  logic                         i_alu_dav,
  input  logic [IDX_W-1:0]             i_alu_dest_index,
  input  logic [31:0]                  i_alu_result,
  input  logic                         i_alu_flags_dav,
  input  logic                         i_alu_c,
  input  logic                         i_mem_dav,
  input  logic [IDX_W-1:0]             i_mem_dest_index,
  input  logic [31:0]                  i_mem_result,
  input  logic                         i_mem_is_load,
  output logic                         o_dav,
  output logic [31:0]                  o_result,
  output logic                         o_carry,
  output logic [IDX_W-1:0]             o_rd_index,
  output logic                         o_stall_from_shifter
);

  localparam int unsigned TypeW = $clog2(SHIFT_OPS);

  // Shift type encoding shared with the decoder.
  localparam logic [TypeW-1:0] OpLsl  = TypeW'(0);
  localparam logic [TypeW-1:0] OpLsr  = TypeW'(1);
  localparam logic [TypeW-1:0] OpAsr  = TypeW'(2);
  localparam logic [TypeW-1:0] OpRor  = TypeW'(3);
  localparam logic [TypeW-1:0] OpRori = TypeW'(4);
  localparam logic [TypeW-1:0] OpRor1 = TypeW'(5);
  localparam logic [TypeW-1:0] OpRrc  = TypeW'(6);

  logic        src_alu_hit, src_mem_hit, amt_alu_hit, amt_mem_hit;
  logic [31:0] src_val, amt_val;
  logic [7:0]  amt;
  logic        shift_cin;
  logic        lock;

  assign src_alu_hit = i_alu_dav && (i_src_index == i_alu_dest_index);
  assign src_mem_hit = i_mem_dav && (i_src_index == i_mem_dest_index);
  assign amt_alu_hit = i_alu_dav && (i_amt_index == i_alu_dest_index);
  assign amt_mem_hit = i_mem_dav && (i_amt_index == i_mem_dest_index);

  always_comb begin
    src_val = i_src_rf_value;
    if (i_src_imm) begin
      src_val = i_imm_value;
    end else if (src_alu_hit) begin
      src_val = i_alu_result;
    end else if (src_mem_hit && !i_mem_is_load) begin
      src_val = i_mem_result;
    end
  end

  always_comb begin
    amt_val = i_amt_rf_value;
    if (amt_alu_hit) begin
      amt_val = i_alu_result;
    end else if (amt_mem_hit && !i_mem_is_load) begin
      amt_val = i_mem_result;
    end
  end

  logic unused_amt_hi;
  assign unused_amt_hi = ^amt_val[31:8];

  assign amt       = i_amt_is_reg ? amt_val[7:0] : i_amt_imm;
  assign shift_cin = i_alu_flags_dav ? i_alu_c : i_cpsr_c;

  // A load in memory blocks an operand unless a younger ALU result already supersedes it.
  assign lock = i_dav && i_mem_dav && i_mem_is_load &&
                ((!i_src_imm && src_mem_hit && !src_alu_hit) ||
                 (i_amt_is_reg && amt_mem_hit && !amt_alu_hit));

  assign o_stall_from_shifter = lock || i_stall_from_alu;

  // Shifter
  logic [5:0]  amt_c;
  logic [32:0] lsl_t, lsr_t, asr_t;
  logic [31:0] rot_t;
  logic [31:0] sh_result;
  logic        sh_carry;

  always_comb begin
    sh_result = src_val;
    sh_carry  = shift_cin;
    amt_c     = (amt > 8'd32) ? 6'd32 : amt[5:0];
    lsl_t     = {1'b0, src_val} << amt_c;
    lsr_t     = {src_val, 1'b0} >> amt_c;
    asr_t     = $signed({src_val, 1'b0}) >>> amt_c;
    rot_t     = (src_val >> amt[4:0]) | (src_val << (6'd32 - {1'b0, amt[4:0]}));
    case (i_shift_type)
      OpLsl: begin
        if (amt > 8'd32) begin
          sh_result = '0;
          sh_carry  = 1'b0;
        end else if (amt != 8'd0) begin
          sh_result = lsl_t[31:0];
          sh_carry  = lsl_t[32];
        end
      end
      OpLsr: begin
        if (amt > 8'd32) begin
          sh_result = '0;
          sh_carry  = 1'b0;
        end else if (amt != 8'd0) begin
          sh_result = lsr_t[32:1];
          sh_carry  = lsr_t[0];
        end
      end
      OpAsr: begin
        if (amt != 8'd0) begin
          sh_result = asr_t[32:1];
          sh_carry  = asr_t[0];
        end
      end
      OpRor: begin
        if (amt != 8'd0) begin
          sh_result = rot_t;
          sh_carry  = rot_t[31];
        end
      end
      OpRori: begin
        sh_result = rot_t;
        sh_carry  = (amt == 8'd0) ? shift_cin : rot_t[31];
      end
      OpRor1: begin
        // Immediate ROR #0 encodes a rotate-through-carry by one.
        if (amt == 8'd0) begin
          sh_result = {shift_cin, src_val[31:1]};
          sh_carry  = src_val[0];
        end else begin
          sh_result = rot_t;
          sh_carry  = rot_t[31];
        end
      end
      OpRrc: begin
        sh_result = {shift_cin, src_val[31:1]};
        sh_carry  = src_val[0];
      end
      default: ;
    endcase
  end

  logic             dav_q;
  logic [31:0]      result_q;
  logic             carry_q;
  logic [IDX_W-1:0] rd_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dav_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      rd_q     <= '0;
    end else if (i_clear_from_alu) begin
      dav_q <= 1'b0;
    end else if (i_stall_from_alu) begin
      dav_q <= dav_q;
    end else if (lock) begin
      dav_q <= 1'b0;
    end else begin
      dav_q    <= i_dav;
      result_q <= sh_result;
      carry_q  <= sh_carry;
      rd_q     <= i_rd_index;
    end
  end

  assign o_dav      = dav_q;
  assign o_result   = result_q;
  assign o_carry    = carry_q;
  assign o_rd_index = rd_q;

endmodule

// File: tb/tb_zap_shift_stage.sv
// Self-checking bench for zap_shift_stage: forwarding, shifts, load-use bubble, stall/clear/reset.
module tb_zap_shift_stage;

  localparam int IDX_W = 6;
  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROR = 3'd3;
  localparam logic [2:0] RORI = 3'd4, ROR1 = 3'd5, RRC = 3'd6;

  typedef struct packed {
    logic [31:0]      res;
    logic             c;
    logic [IDX_W-1:0] rd;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] src;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] res;
    logic        c;
  } vec_t;

  logic             clk, rst;
  logic             clear, stall, dav;
  logic [IDX_W-1:0] src_index, amt_index, rd_index;
  logic             src_imm, amt_is_reg, cpsr_c;
  logic [31:0]      imm_value, src_rf, amt_rf;
  logic [7:0]       amt_imm;
  logic [2:0]       shift_type;
  logic             alu_dav, alu_flags_dav, alu_c;
  logic [IDX_W-1:0] alu_dest, mem_dest;
  logic [31:0]      alu_result, mem_result;
  logic             mem_dav, mem_is_load;
  logic             o_dav, o_carry, o_stall;
  logic [31:0]      o_result;
  logic [IDX_W-1:0] o_rd;

  exp_t sb[$];
  exp_t e;
  vec_t tbl [10];
  int   checks = 0;
  int   errors = 0;

  zap_shift_stage #(.IDX_W(IDX_W), .SHIFT_OPS(7)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_clear_from_alu    (clear),
    .i_stall_from_alu    (stall),
    .i_dav               (dav),
    .i_src_index         (src_index),
    .i_src_imm           (src_imm),
    .i_imm_value         (imm_value),
    .i_src_rf_value      (src_rf),
    .i_amt_index         (amt_index),
    .i_amt_is_reg        (amt_is_reg),
    .i_amt_imm           (amt_imm),
    .i_amt_rf_value      (amt_rf),
    .i_shift_type        (shift_type),
    .i_cpsr_c            (cpsr_c),
    .i_rd_index          (rd_index),
    .i_alu_dav           (alu_dav),
    .i_alu_dest_index    (alu_dest),
    .i_alu_result        (alu_result),
    .i_alu_flags_dav     (alu_flags_dav),
    .i_alu_c             (alu_c),
    .i_mem_dav           (mem_dav),
    .i_mem_dest_index    (mem_dest),
    .i_mem_result        (mem_result),
    .i_mem_is_load       (mem_is_load),
    .o_dav               (o_dav),
    .o_result            (o_result),
    .o_carry             (o_carry),
    .o_rd_index          (o_rd),
    .o_stall_from_shifter(o_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    clear = 0; stall = 0; dav = 0; src_index = 0; src_imm = 0; imm_value = 0; src_rf = 0;
    amt_index = 0; amt_is_reg = 0; amt_imm = 0; amt_rf = 0; shift_type = LSL; cpsr_c = 0;
    rd_index = 0; alu_dav = 0; alu_dest = 0; alu_result = 0; alu_flags_dav = 0; alu_c = 0;
    mem_dav = 0; mem_dest = 0; mem_result = 0; mem_is_load = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    tick();
    tick();
    checks++;
    if ({o_dav, o_result, o_carry, o_rd} !== '0) begin
      errors++;
      $display("FAIL reset: got dav=%b res=%h c=%b rd=%0d, expected all 0",
               o_dav, o_result, o_carry, o_rd);
    end
    rst = 0;
    tick();
    checks++;
    if (o_dav !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_dav: got %b, expected 0", o_dav);
    end
  endtask

  task automatic test_no_hazard();
    idle();
    dav = 1; src_index = 1; src_rf = 32'h1; amt_imm = 8'd4; shift_type = LSL; rd_index = 5;
    sb.push_back('{res: 32'h10, c: 1'b0, rd: 6'd5});
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard_stall: got %b, expected 0", o_stall);
    end
    tick();
    checks++;
    if (o_dav !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL no_hazard_dav: got %b, expected 1", o_dav);
    end else begin
      e = sb.pop_front();
      if ({o_result, o_carry, o_rd} !== e) begin
        errors++;
        $display("FAIL no_hazard: got %h/%b/%0d, expected %h/%b/%0d",
                 o_result, o_carry, o_rd, e.res, e.c, e.rd);
      end
    end
    sb.delete();
  endtask

  task automatic test_forward();
    idle();
    dav = 1; src_index = 2; src_rf = 32'hDEAD_BEEF; amt_imm = 8'd1; shift_type = LSR;
    alu_dav = 1; alu_dest = 2; alu_result = 32'h8000_0000; rd_index = 6;
    mem_dav = 1; mem_dest = 2; mem_result = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) src_rf = 32'h0;
      sb.push_back('{res: 32'h4000_0000, c: 1'b0, rd: 6'd6});
      tick();
      checks++;
      if (o_dav !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL forward_dav[%0d]: got %b, expected 1", i, o_dav);
      end else begin
        e = sb.pop_front();
        if ({o_result, o_carry, o_rd} !== e) begin
          errors++;
          $display("FAIL forward[%0d]: got %h/%b/%0d, expected %h/%b/%0d",
                   i, o_result, o_carry, o_rd, e.res, e.c, e.rd);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_reg_amount();
    idle();
    dav = 1; src_imm = 1; imm_value = 32'h8000_0000; amt_is_reg = 1; amt_index = 3;
    amt_rf = 32'h0000_0001; mem_dav = 1; mem_dest = 3; mem_result = 32'h0000_0120;
    shift_type = ASR; rd_index = 8;
    sb.push_back('{res: 32'hFFFF_FFFF, c: 1'b1, rd: 6'd8});
    tick();
    checks++;
    if (o_dav !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL reg_amount_dav: got %b, expected 1", o_dav);
    end else begin
      e = sb.pop_front();
      if ({o_result, o_carry, o_rd} !== e) begin
        errors++;
        $display("FAIL reg_amount: got %h/%b/%0d, expected %h/%b/%0d",
                 o_result, o_carry, o_rd, e.res, e.c, e.rd);
      end
    end
    sb.delete();
  endtask

  task automatic test_load_use();
    idle();
    dav = 1; src_index = 4; src_rf = 32'h0; amt_imm = 8'd1; shift_type = LSL; rd_index = 9;
    mem_dav = 1; mem_dest = 4; mem_is_load = 1; mem_result = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b, expected 1", o_stall);
    end
    tick();
    checks++;
    if (o_dav !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got dav=%b, expected 0", o_dav);
    end
    mem_dav = 0; src_rf = 32'h100;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: got %b, expected 0", o_stall);
    end
    sb.push_back('{res: 32'h200, c: 1'b0, rd: 6'd9});
    tick();
    checks++;
    if (o_dav !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL load_use_result_dav: got %b, expected 1", o_dav);
    end else begin
      e = sb.pop_front();
      if ({o_result, o_carry, o_rd} !== e) begin
        errors++;
        $display("FAIL load_use_result: got %h/%b/%0d, expected %h/%b/%0d",
                 o_result, o_carry, o_rd, e.res, e.c, e.rd);
      end
    end
    // Amount-register hazard, ALU override, no lock without dav, clear during lock.
    src_index = 1; amt_is_reg = 1; amt_index = 4; mem_dav = 1; mem_dest = 4; mem_is_load = 1;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL amt_load_use_stall: got %b, expected 1", o_stall);
    end
    alu_dav = 1; alu_dest = 4;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_override_stall: got %b, expected 0", o_stall);
    end
    alu_dav = 0; dav = 0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL no_dav_no_lock: got %b, expected 0", o_stall);
    end
    dav = 1; clear = 1;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL clear_lock_stall: got %b, expected 1", o_stall);
    end
    tick();
    checks++;
    if (o_dav !== 1'b0) begin
      errors++;
      $display("FAIL clear_lock_bubble: got %b, expected 0", o_dav);
    end
    sb.delete();
  endtask

  task automatic test_flag_forward();
    idle();
    dav = 1; src_imm = 1; imm_value = 32'h3; shift_type = RRC; cpsr_c = 0;
    alu_flags_dav = 1; alu_c = 1; rd_index = 10;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) sb.push_back('{res: 32'h8000_0001, c: 1'b1, rd: 6'd10});
      else begin
        alu_flags_dav = 0;
        sb.push_back('{res: 32'h0000_0001, c: 1'b1, rd: 6'd10});
      end
      tick();
      checks++;
      if (o_dav !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL flag_forward_dav[%0d]: got %b, expected 1", i, o_dav);
      end else begin
        e = sb.pop_front();
        if ({o_result, o_carry, o_rd} !== e) begin
          errors++;
          $display("FAIL flag_forward[%0d]: got %h/%b/%0d, expected %h/%b/%0d",
                   i, o_result, o_carry, o_rd, e.res, e.c, e.rd);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_boundary();
    tbl[0] = '{op: LSL,  src: 32'h1,         amt: 8'd32,  cin: 0, res: 32'h0,         c: 1};
    tbl[1] = '{op: LSL,  src: 32'h1,         amt: 8'd33,  cin: 1, res: 32'h0,         c: 0};
    tbl[2] = '{op: LSR,  src: 32'h8000_0000, amt: 8'd32,  cin: 0, res: 32'h0,         c: 1};
    tbl[3] = '{op: LSR,  src: 32'hFFFF_FFFF, amt: 8'd40,  cin: 1, res: 32'h0,         c: 0};
    tbl[4] = '{op: ASR,  src: 32'h4000_0000, amt: 8'd200, cin: 1, res: 32'h0,         c: 0};
    tbl[5] = '{op: ROR,  src: 32'h8000_0001, amt: 8'd32,  cin: 0, res: 32'h8000_0001, c: 1};
    tbl[6] = '{op: ROR,  src: 32'h1,         amt: 8'd1,   cin: 0, res: 32'h8000_0000, c: 1};
    tbl[7] = '{op: LSL,  src: 32'h5,         amt: 8'd0,   cin: 1, res: 32'h5,         c: 1};
    tbl[8] = '{op: RORI, src: 32'hF0,        amt: 8'd4,   cin: 1, res: 32'hF,         c: 0};
    tbl[9] = '{op: ROR1, src: 32'h2,         amt: 8'd0,   cin: 1, res: 32'h8000_0001, c: 0};
    idle();
    dav = 1; src_imm = 1;
    for (int i = 0; i < 10; i++) begin
      shift_type = tbl[i].op; imm_value = tbl[i].src; amt_imm = tbl[i].amt;
      cpsr_c = tbl[i].cin; rd_index = 6'(i);
      sb.push_back('{res: tbl[i].res, c: tbl[i].c, rd: 6'(i)});
      tick();
      checks++;
      if (o_dav !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL boundary_dav[%0d]: got %b, expected 1", i, o_dav);
      end else begin
        e = sb.pop_front();
        if ({o_result, o_carry, o_rd} !== e) begin
          errors++;
          $display("FAIL boundary[%0d]: got %h/%b/%0d, expected %h/%b/%0d",
                   i, o_result, o_carry, o_rd, e.res, e.c, e.rd);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    logic [63:0] w;
    idle();
    dav = 1; src_imm = 1; shift_type = LSL; cpsr_c = 1;
    for (int i = 0; i < 8; i++) begin
      s = $urandom();
      w = {32'h0, s} << i;
      imm_value = s; amt_imm = 8'(i); rd_index = 6'(20 + i);
      sb.push_back('{res: w[31:0], c: (i == 0) ? 1'b1 : w[32], rd: 6'(20 + i)});
      tick();
      checks++;
      if (o_dav !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL back_to_back_dav[%0d]: got %b, expected 1", i, o_dav);
      end else begin
        e = sb.pop_front();
        if ({o_result, o_carry, o_rd} !== e) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h/%b/%0d, expected %h/%b/%0d",
                   i, o_result, o_carry, o_rd, e.res, e.c, e.rd);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_control();
    exp_t held;
    idle();
    dav = 1; src_imm = 1; imm_value = 32'hA5; amt_imm = 8'd1; shift_type = LSL; rd_index = 7;
    held = '{res: 32'h14A, c: 1'b0, rd: 6'd7};
    tick();
    checks++;
    if (o_dav !== 1'b1 || {o_result, o_carry, o_rd} !== held) begin
      errors++;
      $display("FAIL control_load: got %b %h/%b/%0d, expected 1 %h/%b/%0d",
               o_dav, o_result, o_carry, o_rd, held.res, held.c, held.rd);
    end
    stall = 1; imm_value = 32'hFFFF; rd_index = 11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_out[%0d]: got %b, expected 1", i, o_stall);
      end
      tick();
      checks++;
      if (o_dav !== 1'b1 || {o_result, o_carry, o_rd} !== held) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b %h/%b/%0d, expected 1 %h/%b/%0d",
                 i, o_dav, o_result, o_carry, o_rd, held.res, held.c, held.rd);
      end
    end
    clear = 1;
    tick();
    checks++;
    if (o_dav !== 1'b0) begin
      errors++;
      $display("FAIL clear_with_stall: got %b, expected 0", o_dav);
    end
    clear = 0; stall = 0;
    tick();
    checks++;
    if (o_dav !== 1'b1) begin
      errors++;
      $display("FAIL control_reload: got %b, expected 1", o_dav);
    end
    stall = 1;
    tick();
    rst = 1;
    #1;
    checks++;
    if ({o_dav, o_result, o_carry, o_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset_mid_stall: got dav=%b res=%h c=%b rd=%0d, expected all 0",
               o_dav, o_result, o_carry, o_rd);
    end
    rst = 0;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_forward();
    test_reg_amount();
    test_load_use();
    test_flag_forward();
    test_boundary();
    test_back_to_back();
    test_control();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_shift_stage.md
Name: zap_shift_stage

Overview:
- Pipeline stage directly upstream of the ALU. It resolves the shift source and shift-amount operands by forwarding from the ALU and memory stages.
- It drives the combinational zap_shift_shifter (LSL/LSR/ASR/ROR/RORI/ROR_1/RRC) and registers the shifted operand and shifter carry-out for the ALU.
- It detects load-use hazards on either operand, stalls the upstream pipeline and inserts a bubble.

Parameters:
- IDX_W, 6, physical register index width.
- SHIFT_OPS, 7, number of shift types; type field width is $clog2(SHIFT_OPS).

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous active-high reset
- i_clear_from_alu  in  1  pipeline flush from ALU (branch/exception)
- i_stall_from_alu  in  1  ALU cannot accept; hold stage
- i_dav  in  1  upstream instruction valid
- i_src_index  in  IDX_W  register index of shift source
- i_src_imm  in  1  1 = source is i_imm_value, no forwarding
- i_imm_value  in  32  immediate source value
- i_src_rf_value  in  32  register-file read of source
- i_amt_index  in  IDX_W  register index of shift amount (register-specified shift)
- i_amt_is_reg  in  1  1 = amount comes from register low byte
- i_amt_imm  in  8  immediate shift amount
- i_amt_rf_value  in  32  register-file read of amount register
- i_shift_type  in  $clog2(SHIFT_OPS)  shift type code
- i_cpsr_c  in  1  architectural C flag
- i_rd_index  in  IDX_W  destination index, passed through
- i_alu_dav, i_alu_dest_index, i_alu_result  in  1/IDX_W/32  ALU-stage writeback candidate
- i_alu_flags_dav, i_alu_c  in  1/1  ALU instruction updates flags / its C result
- i_mem_dav, i_mem_dest_index, i_mem_result, i_mem_is_load  in  1/IDX_W/32/1  memory-stage writeback candidate
- o_dav  out  1  output valid
- o_result  out  32  registered shifted operand
- o_carry  out  1  registered shifter carry-out
- o_rd_index  out  IDX_W  registered destination index
- o_stall_from_shifter  out  1  combinational; upstream must hold inputs

Behaviour:
- Reset (async): o_dav, o_result, o_carry and o_rd_index are all 0. Lock state is cleared.
- Operand resolution is combinational and runs per operand (source, amount register):
  - If i_src_imm=1 (source only), the immediate is used.
  - Else if i_alu_dav and the index matches i_alu_dest_index, i_alu_result is used.
  - Else if i_mem_dav, the index matches, and i_mem_is_load=0, i_mem_result is used.
  - Otherwise the register-file value is used.
  - ALU has priority over memory.
- Shift amount is i_amt_rf_value-resolved [7:0] when i_amt_is_reg=1, else i_amt_imm. The full 8 bits go to the shifter; no truncation.
- Carry into the shifter is i_alu_c when i_alu_flags_dav=1, else i_cpsr_c.
- Hazard: lock = i_dav and i_mem_dav and i_mem_is_load and (source not immediate and source index matches, or i_amt_is_reg and amount index matches). A match in the ALU stage overrides the memory match for that operand, so no lock is raised.
- o_stall_from_shifter = lock or i_stall_from_alu.
- Register update priority at the clock edge:
  1. i_clear_from_alu: o_dav <= 0; other outputs don't-care, held.
  2. i_stall_from_alu: all outputs hold.
  3. lock: o_dav <= 0 (bubble).
  4. Otherwise: o_dav <= i_dav; o_result, o_carry and o_rd_index are loaded from the shifter and inputs.
- Lock lasts exactly as long as the condition holds, normally one cycle. Once the load moves to writeback, the register file supplies the value.
- Latency is 1 cycle from input to registered output. Throughput is 1 per cycle without hazards.
- Clear together with stall: clear wins. Clear together with lock: bubble; o_stall_from_shifter still reflects lock.
- Reset asserted mid-stall or mid-lock: outputs go to 0 immediately.
- i_dav=0: no lock is raised, and a bubble propagates (o_dav <= 0).

Test Plan:
- No hazard: LSL, source r1=0x0000_0001 from RF, immediate amount 4, C=0 → next cycle o_dav=1, o_result=0x10, o_carry=0.
- Forward: ALU writing r2=0x8000_0000 while source=r2, LSR by 1 → o_result=0x4000_0000, o_carry=0. Repeat with an RF value of 0 to confirm forwarding overrides the RF.
- Register amount: amount reg r3 forwarded from memory (non-load) = 0x0000_0120, ASR, source 0x8000_0000 → amount 0x20 used; o_result=0xFFFF_FFFF, o_carry=1.
- Load-use: memory stage load to r4, source=r4 → o_stall_from_shifter=1 for 1 cycle and o_dav=0. The next cycle, with the RF supplying r4, produces the valid result.
- Flag forward: RRC, source 0x0000_0003, CPSR C=0, ALU flags_dav=1 with C=1 → o_result=0x8000_0001, o_carry=1.
- Control: stall for 3 cycles → outputs stable. Clear together with stall → o_dav=0 next cycle. Async reset pulse mid-stall → all outputs 0 without a clock edge.
